// File: rtl/ordinator_pkg.sv
// Shared token-bus definitions for the calculator transmitter and receiver.
package ordinator_pkg;

  localparam logic [1:0] OPERATOR_ADD = 2'd0;
  localparam logic [1:0] OPERATOR_SUB = 2'd1;
  localparam logic [1:0] OPERATOR_EQL = 2'd2;
  localparam logic [1:0] OPERATOR_CLR = 2'd3;

  localparam logic [7:0] MIN_OPERAND = 8'd4;

  typedef enum logic [2:0] {
    IDLE,
    EXPECT_NUM,
    EXPECT_OP,
    WAIT_RES,
    ABORT,
    DONE
  } tx_state_t;

  // Operator codes travel on the bus zero-extended to a full token.
  function automatic logic [7:0] op_token(input logic [1:0] code);
    return {6'd0, code};
  endfunction

endpackage

// File: rtl/token_fifo.sv
// Tagged expression FIFO: first-word-fall-through head, synchronous flush.
module token_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      count;

  // One extra pointer bit distinguishes full from empty when the indices match.
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en && !full) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en && !empty) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/expr_token_tx.sv
// Expression token transmitter: grammar-checks the FIFO and streams tokens to the calculator.
// Optional EXPR_AUTO_EQL_EN: an exhausted FIFO after an operand sends an implicit EQL.
module expr_token_tx
  import ordinator_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_is_op,
  input  logic [7:0] wr_data,
  output logic       full,
  input  logic       start,
  output logic       busy,
  output logic [7:0] tok_out,
  output logic       tok_valid,
  input  logic       tok_ready,
  input  logic [7:0] result_in,
  input  logic       result_valid,
  output logic [7:0] result_out,
  output logic       done,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  tx_state_t     state_reg;
  logic [TW-1:0] timer_reg;
  logic [8:0]    head;
  logic          fifo_empty;
  logic          wr_ok;
  logic          xfer;
  logic          pop;
  logic          flush;

  assign wr_ok = wr_en && (state_reg == IDLE) && !full;
  assign xfer  = tok_valid && tok_ready;
  assign pop   = xfer && !fifo_empty && ((state_reg == EXPECT_NUM) || (state_reg == EXPECT_OP));
  assign flush = xfer && (state_reg == ABORT);

  token_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_data ({wr_is_op, wr_data}),
    .rd_en   (pop),
    .flush   (flush),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (full)
  );

  // Token is decoded from registered state and FIFO head, so it holds until popped.
  always_comb begin
    tok_valid = 1'b0;
    tok_out   = 8'd0;
    case (state_reg)
      EXPECT_NUM: begin
        if (!fifo_empty && !head[8] && (head[7:0] >= MIN_OPERAND)) begin
          tok_valid = 1'b1;
          tok_out   = head[7:0];
        end
      end
      EXPECT_OP: begin
        if (!fifo_empty && head[8] && (head[1:0] != OPERATOR_CLR)) begin
          tok_valid = 1'b1;
          tok_out   = op_token(head[1:0]);
        end
`ifdef EXPR_AUTO_EQL_EN
        else if (fifo_empty) begin
          tok_valid = 1'b1;
          tok_out   = op_token(OPERATOR_EQL);
        end
`endif
      end
      ABORT: begin
        tok_valid = 1'b1;
        tok_out   = op_token(OPERATOR_CLR);
      end
      default: begin
        tok_valid = 1'b0;
        tok_out   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      result_out <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            err       <= 1'b0;
            busy      <= 1'b1;
            state_reg <= (fifo_empty && !wr_ok) ? ABORT : EXPECT_NUM;
          end
        end
        EXPECT_NUM: begin
          if (!tok_valid) begin
            state_reg <= ABORT;
          end else if (tok_ready) begin
            state_reg <= EXPECT_OP;
          end
        end
        EXPECT_OP: begin
          if (!tok_valid) begin
            state_reg <= ABORT;
          end else if (tok_ready) begin
            timer_reg <= '0;
            state_reg <= (tok_out[1:0] == OPERATOR_EQL) ? WAIT_RES : EXPECT_NUM;
          end
        end
        WAIT_RES: begin
          if (result_valid) begin
            result_out <= result_in;
            done       <= 1'b1;
            state_reg  <= DONE;
          end else if (timer_reg >= TW'(TIMEOUT - 1)) begin
            err       <= 1'b1;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ABORT: begin
          err <= 1'b1;
          if (tok_ready) begin
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
      // A dropped host write is reported even if a start clears err this cycle.
      if (wr_en && !wr_ok) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/expr_token_tx.md
Name: expr_token_tx

Overview:
Transmitter for the 8-bit calculator token bus. The host loads an expression into a small tagged FIFO: operands, plus operator codes 0=ADD, 1=SUB, 2=EQL, 3=CLR. On start, the block checks the grammar and emits one token per accepted handshake, then waits for the calculator's result. It sits between host/testbench stimulus and the calculator's `in` port.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
TIMEOUT, 15, max cycles waiting for result_valid after EQL is sent

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  reset, synchronous, active-low
wr_en  in  1  push {wr_is_op, wr_data} into FIFO
wr_is_op  in  1  1 = operator entry (wr_data[1:0] is the code), 0 = operand
wr_data  in  8  operand value or operator code
full  out  1  FIFO full
start  in  1  begin transmitting the FIFO contents
busy  out  1  high from the cycle after an accepted start until done
tok_out  out  8  token on the calculator bus
tok_valid  out  1  tok_out is valid
tok_ready  in  1  calculator accepts the token
result_in  in  8  calculator result
result_valid  in  1  result_in is valid
result_out  out  8  captured result
done  out  1  one-cycle pulse at end of a transaction
err  out  1  sticky error, cleared by the next accepted start

Behaviour:
- Reset, applied when reset==0 at a clk edge: state IDLE, FIFO emptied, tok_valid=0, tok_out=0, busy=0, done=0, err=0, result_out=0, full=0.
- Reset mid-transaction aborts immediately. No CLR token is emitted.
- Handshake: a transfer occurs on a clk edge where tok_valid && tok_ready.
  - tok_out stays stable while tok_valid=1 and tok_ready=0.
  - tok_out=0 whenever tok_valid=0.
  - Back-to-back tokens are allowed: at most 1 token per cycle.
- FIFO writes:
  - Accepted only in IDLE with full=0.
  - A write while full or busy is dropped and sets err.
  - A simultaneous wr_en and start in IDLE: the write is accepted first; start takes effect the same cycle with the new entry included.
- start is ignored unless state is IDLE.
- State machine:
  - IDLE: on start, clear err. Go to EXPECT_NUM, or to ABORT if the FIFO is empty.
  - EXPECT_NUM: pop the head entry. It must be an operand with value >3.
    - Valid operand: present it on tok_out, then go to EXPECT_OP after the transfer.
    - Operator entry, operand <=3, or FIFO empty: go to ABORT.
  - EXPECT_OP: pop the head entry. It must be an operator.
    - ADD or SUB: send it, then go to EXPECT_NUM.
    - EQL: send it, then go to WAIT_RES.
    - CLR, an operand entry, or FIFO empty: go to ABORT.
  - WAIT_RES: tok_valid=0.
    - result_valid: capture result_out<=result_in, go to DONE.
    - No result_valid after TIMEOUT cycles: set err, go to DONE. result_out is unchanged.
  - ABORT: set err, send token 3 (CLR) with the normal handshake, flush the FIFO, go to DONE.
  - DONE: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- FIFO boundaries:
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - full when the count equals DEPTH; empty when the count is 0.
  - A pop happens only on the handshake cycle of the popped token.
- Timeout counter: $clog2(TIMEOUT+1) bits. It resets on entry to WAIT_RES and saturates.

Optional Feature:
Macro: EXPR_AUTO_EQL_EN.
- Defined: in EXPECT_OP with the FIFO empty, the block synthesises and sends EQL (token 2), then goes to WAIT_RES. No error is raised.
- Undefined: an empty FIFO in EXPECT_OP goes to ABORT, as listed above.

Decomposition:
- Shared package ordinator_pkg holds:
  - token codes OPERATOR_ADD=2'd0, SUB=2'd1, EQL=2'd2, CLR=2'd3;
  - MIN_OPERAND=8'd4;
  - the tx state enum {IDLE, EXPECT_NUM, EXPECT_OP, WAIT_RES, ABORT, DONE}.
- The calculator receiver reuses the same package.
- Sub-module token_fifo (DEPTH x 9 bits, synchronous, flush input) holds the storage. The FSM stays in expr_token_tx.

Test Plan:
- Load 10, ADD, 5, EQL; tok_ready=1; start; result 15 returned 2 cycles after EQL -> tokens 10,0,5,2 on 4 consecutive cycles; result_out=15; done pulse; err=0.
- Load 20, SUB, 7, EQL; tok_ready toggles 1/0 each cycle -> each token held stable while tok_ready=0; same order 20,1,7,2; result 13 captured.
- Load 2, ADD, 5 -> first popped operand is <=3, so ABORT: token 3 sent, err=1, FIFO empty, done pulse.
- Load 9, ADD, 6 with no EQL -> macro off: tokens 9,0,6,3 and err=1. Macro on: tokens 9,0,6,2 then WAIT_RES.
- Fill DEPTH=8 entries then a 9th write -> full=1, 9th write dropped, err=1. Send EQL with no result_valid -> after 15 cycles err=1, done pulse, result_out unchanged.
- reset=0 asserted while waiting on tok_ready mid-stream -> next edge: tok_valid=0, busy=0, FIFO empty, all outputs at reset values.
